// File: rtl/core_lsu.sv
// core_lsu: load/store unit between the core memory stage and the data bus.
//   - Memory-stage side (m_*): one request per cycle. stall_o asks the pipeline to hold it.
//     misaligned_o pulses one cycle after a misaligned request is dropped.
//   - Bus side (data_*): req/gnt handshake. A command stays stable while data_req_o is high.
//     Responses (data_rvalid_i) arrive in grant order, one per grant.
//   - Writeback (w_*): aligned, extended load result, valid for one cycle.
//   - protocol_err_o: sticky flag, set by an rvalid that arrives with nothing outstanding.
// DATA_WIDTH must be at least 16 bits so that half-word replication is defined.
module core_lsu #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m_req_i,
  input  logic                      m_wr_i,
  input  logic [ADDR_WIDTH-1:0]     m_addr_i,
  input  logic [DATA_WIDTH-1:0]     m_wdata_i,
  input  logic [1:0]                m_size_i,
  input  logic                      m_unsigned_i,
  input  logic [REG_ADDR_WIDTH-1:0] m_waddr_i,
  output logic                      stall_o,
  output logic                      misaligned_o,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  output logic [ADDR_WIDTH-1:0]     data_addr_o,
  output logic                      data_wr_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   data_be_o,
  input  logic                      data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  output logic                      w_valid_o,
  output logic [DATA_WIDTH-1:0]     w_rdata_o,
  output logic [REG_ADDR_WIDTH-1:0] w_waddr_o,
  output logic                      protocol_err_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Off      = $clog2(NumBytes);
  localparam int unsigned OffW     = (Off > 0) ? Off : 1;
  localparam int unsigned PtrW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW     = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [PtrW-1:0]       LastPtr  = PtrW'(MAX_OUTSTANDING - 1);
  localparam logic [CntW:0]         MaxOcc   = (CntW + 1)'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] LaneMask = ADDR_WIDTH'(NumBytes - 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  // Everything needed to post-process the response of one granted transfer.
  typedef struct packed {
    logic [OffW-1:0]           off;
    logic [1:0]                size;
    logic                      uns;
    logic [REG_ADDR_WIDTH-1:0] waddr;
    logic                      is_load;
  } entry_t;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     cmd_addr_q;
  logic                      cmd_wr_q;
  logic [DATA_WIDTH-1:0]     cmd_wdata_q;
  logic [NumBytes-1:0]       cmd_be_q;
  entry_t                    cmd_ent_q;

  entry_t                    fifo_q [MAX_OUTSTANDING];
  logic [PtrW-1:0]           wptr_q, rptr_q;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic                      misaligned_q;
  logic                      w_valid_q;
  logic [DATA_WIDTH-1:0]     w_rdata_q;
  logic [REG_ADDR_WIDTH-1:0] w_waddr_q;
  logic                      protocol_err_q;

  // Request decode
  logic [OffW-1:0]       off_in;
  logic                  aligned;
  logic [NumBytes-1:0]   be_in;
  logic [DATA_WIDTH-1:0] wdata_in;
  logic [CntW:0]         occ;
  logic                  slot_free;
  logic                  accept;
  logic                  push;
  logic                  pop;

  always_comb begin
    off_in   = (Off > 0) ? m_addr_i[OffW-1:0] : '0;
    aligned  = 1'b1;
    be_in    = '1;
    wdata_in = m_wdata_i;
    unique case (m_size_i)
      2'd0: begin
        be_in    = NumBytes'(1) << off_in;
        wdata_in = {NumBytes{m_wdata_i[7:0]}};
      end
      2'd1: begin
        aligned  = ~m_addr_i[0];
        be_in    = NumBytes'(3) << off_in;
        wdata_in = {(NumBytes / 2){m_wdata_i[15:0]}};
      end
      default: begin
        // Size 3 is reserved and handled as a full word.
        aligned = (off_in == '0);
      end
    endcase
  end

  // The command sitting in REQ will occupy a slot once granted, so it counts here.
  // A response this cycle frees a slot in time for the new command.
  assign occ       = {1'b0, cnt_q} + {{CntW{1'b0}}, (state_q == StReq)};
  assign slot_free = (occ < MaxOcc) | data_rvalid_i;
  assign accept    = m_req_i & ((state_q == StIdle) | data_gnt_i) & slot_free & aligned;
  assign stall_o   = m_req_i & aligned & ~accept;

  assign push = (state_q == StReq) & data_gnt_i;
  assign pop  = data_rvalid_i & (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StReq;
      StReq:  if (data_gnt_i) state_d = accept ? StReq : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Response alignment and extension, driven from the FIFO head.
  entry_t                head;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_data;

  always_comb begin
    head      = fifo_q[rptr_q];
    shifted   = data_rdata_i >> {head.off, 3'b000};
    load_data = shifted;
    unique case (head.size)
      2'd0: load_data = head.uns ? {{(DATA_WIDTH - 8){1'b0}}, shifted[7:0]}
                                 : {{(DATA_WIDTH - 8){shifted[7]}}, shifted[7:0]};
      2'd1: load_data = head.uns ? {{(DATA_WIDTH - 16){1'b0}}, shifted[15:0]}
                                 : {{(DATA_WIDTH - 16){shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cmd_addr_q     <= '0;
      cmd_wr_q       <= 1'b0;
      cmd_wdata_q    <= '0;
      cmd_be_q       <= '0;
      cmd_ent_q      <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      cnt_q          <= '0;
      misaligned_q   <= 1'b0;
      w_valid_q      <= 1'b0;
      w_rdata_q      <= '0;
      w_waddr_q      <= '0;
      protocol_err_q <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      misaligned_q <= m_req_i & ~aligned;
      w_valid_q    <= pop & head.is_load;

      if (accept) begin
        cmd_addr_q        <= m_addr_i & ~LaneMask;
        cmd_wr_q          <= m_wr_i;
        cmd_wdata_q       <= wdata_in;
        cmd_be_q          <= be_in;
        cmd_ent_q.off     <= off_in;
        cmd_ent_q.size    <= m_size_i;
        cmd_ent_q.uns     <= m_unsigned_i;
        cmd_ent_q.waddr   <= m_waddr_i;
        cmd_ent_q.is_load <= ~m_wr_i;
      end

      if (push) begin
        fifo_q[wptr_q] <= cmd_ent_q;
        wptr_q         <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
      end

      if (pop) begin
        rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
        if (head.is_load) begin
          w_rdata_q <= load_data;
          w_waddr_q <= head.waddr;
        end
      end

      if (data_rvalid_i && (cnt_q == '0)) protocol_err_q <= 1'b1;
    end
  end

  assign data_req_o     = (state_q == StReq);
  assign data_addr_o    = cmd_addr_q;
  assign data_wr_o      = cmd_wr_q;
  assign data_wdata_o   = cmd_wdata_q;
  assign data_be_o      = cmd_be_q;
  assign misaligned_o   = misaligned_q;
  assign w_valid_o      = w_valid_q;
  assign w_rdata_o      = w_rdata_q;
  assign w_waddr_o      = w_waddr_q;
  assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu with default parameters (32-bit data, 2 outstanding).
module tb_core_lsu;

  logic        clk;
  logic        rst_n;
  logic        m_req_i;
  logic        m_wr_i;
  logic [31:0] m_addr_i;
  logic [31:0] m_wdata_i;
  logic [1:0]  m_size_i;
  logic        m_unsigned_i;
  logic [4:0]  m_waddr_i;
  logic        stall_o;
  logic        misaligned_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_wr_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        w_valid_o;
  logic [31:0] w_rdata_o;
  logic [4:0]  w_waddr_o;
  logic        protocol_err_o;

  int n_total  = 0;
  int n_passed = 0;

  core_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_req_i       (m_req_i),
    .m_wr_i        (m_wr_i),
    .m_addr_i      (m_addr_i),
    .m_wdata_i     (m_wdata_i),
    .m_size_i      (m_size_i),
    .m_unsigned_i  (m_unsigned_i),
    .m_waddr_i     (m_waddr_i),
    .stall_o       (stall_o),
    .misaligned_o  (misaligned_o),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_addr_o   (data_addr_o),
    .data_wr_o     (data_wr_o),
    .data_wdata_o  (data_wdata_o),
    .data_be_o     (data_be_o),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .w_valid_o     (w_valid_o),
    .w_rdata_o     (w_rdata_o),
    .w_waddr_o     (w_waddr_o),
    .protocol_err_o(protocol_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [4:0] waddr);
    m_req_i      = req;
    m_wr_i       = wr;
    m_addr_i     = addr;
    m_wdata_i    = wdata;
    m_size_i     = size;
    m_unsigned_i = uns;
    m_waddr_i    = waddr;
  endtask

  initial begin
    rst_n         = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    #3;
    chk("rst_req", data_req_o, 0);
    chk("rst_wvalid", w_valid_o, 0);
    chk("rst_perr", protocol_err_o, 0);
    chk("rst_mis", misaligned_o, 0);
    chk("rst_stall", stall_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // lb 0x103, sign-extended top byte
    drive(1'b1, 1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 5'd5);
    #1 chk("t1_stall", stall_o, 0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    data_gnt_i = 1'b1;
    #1;
    chk("t1_req", data_req_o, 1);
    chk("t1_addr", data_addr_o, 32'h100);
    chk("t1_be", data_be_o, 4'b1000);
    chk("t1_wr", data_wr_o, 0);
    tick();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h80FF_1234;
    #1 chk("t1_req_drop", data_req_o, 0);
    tick();
    data_rvalid_i = 1'b0;
    chk("t1_wvalid", w_valid_o, 1);
    chk("t1_wdata", w_rdata_o, 32'hFFFF_FF80);
    chk("t1_waddr", w_waddr_o, 5'd5);
    tick();
    chk("t1_wvalid_1cyc", w_valid_o, 0);

    // sh 0xABCD to 0x202, immediate grant
    drive(1'b1, 1'b1, 32'h202, 32'h0000_ABCD, 2'd1, 1'b0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    data_gnt_i = 1'b1;
    #1;
    chk("t2_wdata", data_wdata_o, 32'hABCD_ABCD);
    chk("t2_be", data_be_o, 4'b1100);
    chk("t2_wr", data_wr_o, 1);
    chk("t2_addr", data_addr_o, 32'h200);
    tick();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h5555_5555;
    tick();
    data_rvalid_i = 1'b0;
    chk("t2_no_wvalid", w_valid_o, 0);
    chk("t2_perr", protocol_err_o, 0);

    // lw 0x301 is misaligned
    drive(1'b1, 1'b0, 32'h301, 32'h0, 2'd2, 1'b0, 5'd4);
    #1 chk("t3_stall", stall_o, 0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    chk("t3_mis", misaligned_o, 1);
    chk("t3_req", data_req_o, 0);
    tick();
    chk("t3_mis_pulse", misaligned_o, 0);
    chk("t3_req2", data_req_o, 0);

    // three back-to-back lw, limit of two outstanding
    drive(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5'd1);
    tick();
    drive(1'b1, 1'b0, 32'h14, 32'h0, 2'd2, 1'b0, 5'd2);
    data_gnt_i = 1'b1;
    #1 chk("t4_acc2", stall_o, 0);
    tick();
    drive(1'b1, 1'b0, 32'h18, 32'h0, 2'd2, 1'b0, 5'd3);
    #1;
    chk("t4_stall3", stall_o, 1);
    chk("t4_addr2", data_addr_o, 32'h14);
    tick();
    #1;
    chk("t4_stall3b", stall_o, 1);
    chk("t4_req_idle", data_req_o, 0);
    tick();
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h1111_1111;
    #1 chk("t4_acc3", stall_o, 0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    data_rdata_i = 32'h2222_2222;
    chk("t4_w1_valid", w_valid_o, 1);
    chk("t4_w1_addr", w_waddr_o, 5'd1);
    chk("t4_w1_data", w_rdata_o, 32'h1111_1111);
    chk("t4_addr3", data_addr_o, 32'h18);
    chk("t4_req3", data_req_o, 1);
    tick();
    data_gnt_i   = 1'b0;
    data_rdata_i = 32'h3333_3333;
    chk("t4_w2_addr", w_waddr_o, 5'd2);
    chk("t4_w2_data", w_rdata_o, 32'h2222_2222);
    tick();
    data_rvalid_i = 1'b0;
    chk("t4_w3_addr", w_waddr_o, 5'd3);
    chk("t4_w3_data", w_rdata_o, 32'h3333_3333);
    tick();
    chk("t4_wvalid_end", w_valid_o, 0);

    // lhu 0x42 with grant delayed three cycles, lw 0x50 waiting behind it
    drive(1'b1, 1'b0, 32'h42, 32'h0, 2'd1, 1'b1, 5'd7);
    tick();
    drive(1'b1, 1'b0, 32'h50, 32'h0, 2'd2, 1'b0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_req", data_req_o, 1);
      chk("t5_addr", data_addr_o, 32'h40);
      chk("t5_be", data_be_o, 4'b1100);
      chk("t5_stall", stall_o, 1);
      tick();
    end
    data_gnt_i = 1'b1;
    #1 chk("t5_acc", stall_o, 0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    #1;
    chk("t5_addr2", data_addr_o, 32'h50);
    chk("t5_be2", data_be_o, 4'b1111);
    tick();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hF00D_1234;
    tick();
    data_rdata_i = 32'hDEAD_BEEF;
    chk("t5_w1_addr", w_waddr_o, 5'd7);
    chk("t5_w1_data", w_rdata_o, 32'h0000_F00D);
    tick();
    data_rvalid_i = 1'b0;
    chk("t5_w2_addr", w_waddr_o, 5'd8);
    chk("t5_w2_data", w_rdata_o, 32'hDEAD_BEEF);
    chk("t5_perr", protocol_err_o, 0);
    tick();

    // reset with two loads in flight, then a stray response
    drive(1'b1, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd9);
    tick();
    drive(1'b1, 1'b0, 32'h1, 32'h0, 2'd0, 1'b0, 5'd10);
    data_gnt_i = 1'b1;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    #1 chk("t6_be2", data_be_o, 4'b0010);
    tick();
    data_gnt_i = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("t6_rst_req", data_req_o, 0);
    chk("t6_rst_addr", data_addr_o, 0);
    chk("t6_rst_wvalid", w_valid_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_perr_clear", protocol_err_o, 0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h1234_5678;
    tick();
    data_rvalid_i = 1'b0;
    chk("t6_perr", protocol_err_o, 1);
    chk("t6_wvalid", w_valid_o, 0);
    tick();
    chk("t6_perr_sticky", protocol_err_o, 1);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
